// File: rtl/sdram_port_arbiter_pkg.sv
// Shared command codes, burst-owner encoding and default geometry for the SDRAM port arbiter.
package sdram_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_WR256 = 2'b01,
        CMD_RD32  = 2'b10,
        CMD_RD256 = 2'b11
    } sys_cmd_t;

    typedef enum logic {
        OWN_VIDEO = 1'b0,
        OWN_CACHE = 1'b1
    } owner_t;

    // 640*480 pixels / 32-byte bursts / 8 -> 1200 bursts per frame
    localparam int unsigned DEF_VID_LAST     = 1199;
    localparam logic [7:0]  DEF_VID_BASE     = 8'h80;
    localparam int unsigned DEF_STARVE_LIMIT = 64;

    function automatic logic [11:0] vid_next(input logic [11:0] cur, input logic [11:0] last);
        return (cur == last) ? 12'd0 : cur + 12'd1;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Command/acknowledge/beat bus between the arbiter (master) and the SDRAM_16bit controller (slave).
interface sdram_port_arbiter_if;

    logic [1:0]  sys_cmd;
    logic [22:0] sys_addr;
    logic [1:0]  sys_cmd_ack;
    logic        sys_rd_data_valid;
    logic        sys_wr_data_valid;
    logic [15:0] sys_dout;

    modport master (
        output sys_cmd,
        output sys_addr,
        input  sys_cmd_ack,
        input  sys_rd_data_valid,
        input  sys_wr_data_valid,
        input  sys_dout
    );

    modport slave (
        input  sys_cmd,
        input  sys_addr,
        output sys_cmd_ack,
        output sys_rd_data_valid,
        output sys_wr_data_valid,
        output sys_dout
    );

endinterface

// File: rtl/sdram_port_arbiter_vid_packer.sv
// Packs pairs of 16-bit video read beats into 32-bit video queue words {second, first}.
module vid_packer
    import sdram_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ack_edge,
    input  owner_t      owner,
    input  logic        rd_valid,
    input  logic [15:0] beat,
    output logic        vq_wr_en,
    output logic [31:0] vq_data
);

    logic        half;
    logic [15:0] held;
    logic        beat_valid;

    assign beat_valid = (owner == OWN_VIDEO) && rd_valid;

    // A new burst always starts on the low half, so an odd leftover beat is discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            half     <= 1'b0;
            held     <= '0;
            vq_wr_en <= 1'b0;
            vq_data  <= '0;
        end else begin
            vq_wr_en <= 1'b0;
            if (ack_edge) begin
                half <= 1'b0;
            end else if (beat_valid) begin
                if (!half) begin
                    held <= beat;
                    half <= 1'b1;
                end else begin
                    vq_data  <= {beat, held};
                    vq_wr_en <= 1'b1;
                    half     <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// SDRAM command arbiter between the video queue and the cache line engine.
// Optional macro SDRAM_VSYNC_RESYNC_EN: realign the video burst index to 0 on vsync.
module sdram_port_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned VID_LAST     = DEF_VID_LAST,
    parameter logic [7:0]  VID_BASE     = DEF_VID_BASE,
    parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                 clk,
    input  logic                 rst,
    sdram_port_arbiter_if.master sdram,
    input  logic                 vq_almost_empty,
    input  logic                 cache_wr_req,
    input  logic                 cache_rd_req,
    input  logic [16:0]          cache_waddr,
    input  logic [16:0]          cpu_line_addr,
    input  logic                 vsync,
    output logic                 vq_wr_en,
    output logic [31:0]          vq_data,
    output logic                 cache_write_data,
    output logic                 cache_read_data,
    output logic [11:0]          vid_addr
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [11:0] VID_LAST_W = 12'(VID_LAST);

    sys_cmd_t      cmd_r;
    logic [SW-1:0] starve_cnt;
    owner_t        owner;
    logic          ack_idle;
    logic          cache_pend;
    sys_cmd_t      cache_cmd;
    logic          ack_edge;
    logic          vid_ack_edge;

    always_comb begin
        cache_pend = cache_wr_req | cache_rd_req;
        if (cache_wr_req)      cache_cmd = CMD_WR256;
        else if (cache_rd_req) cache_cmd = CMD_RD256;
        else                   cache_cmd = CMD_NOP;
    end

    // Starved cache requests get one forced slot, after which video regains priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_r      <= CMD_NOP;
            starve_cnt <= '0;
        end else if (cache_pend && (!vq_almost_empty || starve_cnt == SW'(STARVE_LIMIT))) begin
            cmd_r      <= cache_cmd;
            starve_cnt <= '0;
        end else if (vq_almost_empty) begin
            cmd_r      <= CMD_RD32;
            starve_cnt <= cache_pend ? starve_cnt + 1'b1 : '0;
        end else begin
            cmd_r      <= CMD_NOP;
            starve_cnt <= '0;
        end
    end

    assign sdram.sys_cmd = cmd_r;

    always_comb begin
        sdram.sys_addr = '0;
        unique case (cmd_r)
            CMD_WR256: sdram.sys_addr = {cache_waddr, 6'b0};
            CMD_RD32:  sdram.sys_addr = {VID_BASE, vid_addr, 3'b0};
            CMD_RD256: sdram.sys_addr = {cpu_line_addr, 6'b0};
            default:   sdram.sys_addr = '0;
        endcase
    end

    assign ack_edge     = ack_idle && (sdram.sys_cmd_ack != 2'b00);
    assign vid_ack_edge = ack_edge && (sdram.sys_cmd_ack == 2'b10);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_idle <= 1'b1;
            owner    <= OWN_VIDEO;
        end else begin
            ack_idle <= (sdram.sys_cmd_ack == 2'b00);
            if (ack_edge)
                owner <= (sdram.sys_cmd_ack == 2'b10) ? OWN_VIDEO : OWN_CACHE;
        end
    end

`ifdef SDRAM_VSYNC_RESYNC_EN
    logic [1:0] vs_sync;
    logic       vs_prev;
    logic       resync_pend;
    logic       vs_rise;

    assign vs_rise = vs_sync[1] && !vs_prev;

    // A rise coincident with an ack edge stays pending for the following burst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_sync     <= '0;
            vs_prev     <= 1'b0;
            resync_pend <= 1'b0;
            vid_addr    <= '0;
        end else begin
            vs_sync     <= {vs_sync[0], vsync};
            vs_prev     <= vs_sync[1];
            resync_pend <= (resync_pend && !vid_ack_edge) || vs_rise;
            if (vid_ack_edge)
                vid_addr <= resync_pend ? 12'd0 : vid_next(vid_addr, VID_LAST_W);
        end
    end
`else
    logic unused_vsync;
    assign unused_vsync = vsync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            vid_addr <= '0;
        else if (vid_ack_edge)
            vid_addr <= vid_next(vid_addr, VID_LAST_W);
    end
`endif

    assign cache_write_data = (owner == OWN_CACHE) && sdram.sys_rd_data_valid;
    assign cache_read_data  = (owner == OWN_CACHE) && sdram.sys_wr_data_valid;

    vid_packer u_vid_packer (
        .clk      (clk),
        .rst      (rst),
        .ack_edge (ack_edge),
        .owner    (owner),
        .rd_valid (sdram.sys_rd_data_valid),
        .beat     (sdram.sys_dout),
        .vq_wr_en (vq_wr_en),
        .vq_data  (vq_data)
    );

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: randomized requests/bursts against a behavioural model.
module tb_sdram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vq_almost_empty = 1'b0;
    logic        cache_wr_req = 1'b0;
    logic        cache_rd_req = 1'b0;
    logic [16:0] cache_waddr = '0;
    logic [16:0] cpu_line_addr = '0;
    logic        vsync = 1'b0;
    logic        vq_wr_en;
    logic [31:0] vq_data;
    logic        cache_write_data;
    logic        cache_read_data;
    logic [11:0] vid_addr;

    sdram_port_arbiter_if bus();

    sdram_port_arbiter #(
        .VID_LAST     (1199),
        .VID_BASE     (8'h80),
        .STARVE_LIMIT (64)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .sdram            (bus),
        .vq_almost_empty  (vq_almost_empty),
        .cache_wr_req     (cache_wr_req),
        .cache_rd_req     (cache_rd_req),
        .cache_waddr      (cache_waddr),
        .cpu_line_addr    (cpu_line_addr),
        .vsync            (vsync),
        .vq_wr_en         (vq_wr_en),
        .vq_data          (vq_data),
        .cache_write_data (cache_write_data),
        .cache_read_data  (cache_read_data),
        .vid_addr         (vid_addr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [1:0]  cmd_q[$];
    logic [31:0] vq_q[$];
    logic [11:0] ref_vid = '0;
    bit          ref_cache = 1'b0;
    bit          m_idle = 1'b1;
    int          m_starve = 0;
    bit          m_pend = 1'b0;
    bit          m_vs_prev = 1'b0;
    int          vq_pulses = 0;
    int          cwd_pulses = 0;
    int          crd_pulses = 0;
    bit          rand_reqs = 1'b0;

    always @(posedge clk) begin : model
        logic [1:0] e;
        bit pend;
        if (!rst) begin
            ref_vid   = '0;
            ref_cache = 1'b0;
            m_idle    = 1'b1;
            m_starve  = 0;
            m_pend    = 1'b0;
            m_vs_prev = 1'b0;
            cmd_q.push_back(2'b00);
        end else begin
            pend = cache_wr_req || cache_rd_req;
            if (pend && (m_starve >= 64 || !vq_almost_empty)) begin
                e = cache_wr_req ? 2'b01 : 2'b11;
                m_starve = 0;
            end else if (vq_almost_empty) begin
                e = 2'b10;
                m_starve = pend ? m_starve + 1 : 0;
            end else begin
                e = 2'b00;
                m_starve = 0;
            end
            cmd_q.push_back(e);
            if (m_idle && bus.sys_cmd_ack != 2'b00) begin
                ref_cache = (bus.sys_cmd_ack != 2'b10);
                if (bus.sys_cmd_ack == 2'b10) begin
                    if (m_pend) begin
                        ref_vid = '0;
                        m_pend  = 1'b0;
                    end else begin
                        ref_vid = (ref_vid == 12'd1199) ? 12'd0 : ref_vid + 12'd1;
                    end
                end
            end
            m_idle = (bus.sys_cmd_ack == 2'b00);
`ifdef SDRAM_VSYNC_RESYNC_EN
            if (vsync && !m_vs_prev) m_pend = 1'b1;
`endif
            m_vs_prev = vsync;
        end
    end

    always @(negedge clk) begin : monitor
        logic [1:0]  e;
        logic [22:0] ea;
        if (cmd_q.size() > 0) begin
            e = cmd_q.pop_front();
            case (e)
                2'b01:   ea = {cache_waddr, 6'b0};
                2'b10:   ea = {8'h80, ref_vid, 3'b0};
                2'b11:   ea = {cpu_line_addr, 6'b0};
                default: ea = '0;
            endcase
            chk("sys_cmd", 64'(bus.sys_cmd), 64'(e));
            chk("sys_addr", 64'(bus.sys_addr), 64'(ea));
        end
        chk("vid_addr", 64'(vid_addr), 64'(ref_vid));
        chk("cache_write_data", 64'(cache_write_data), 64'(ref_cache && bus.sys_rd_data_valid));
        chk("cache_read_data", 64'(cache_read_data), 64'(ref_cache && bus.sys_wr_data_valid));
        if (vq_wr_en === 1'b1) begin
            vq_pulses++;
            if (vq_q.size() == 0) chk("vq_wr_en_unexpected", 64'(1), 64'(0));
            else                  chk("vq_data", 64'(vq_data), 64'(vq_q.pop_front()));
        end
        if (cache_write_data === 1'b1) cwd_pulses++;
        if (cache_read_data === 1'b1)  crd_pulses++;
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_reqs) begin
            vq_almost_empty = ($urandom_range(0, 3) != 0);
            cache_wr_req    = ($urandom_range(0, 5) == 0);
            cache_rd_req    = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) cache_waddr   = 17'($urandom);
            if ($urandom_range(0, 7) == 0) cpu_line_addr = 17'($urandom);
        end
    endtask

    task automatic do_ack(input logic [1:0] code, input int hold);
        repeat (hold) begin
            step();
            bus.sys_cmd_ack = code;
        end
        step();
        bus.sys_cmd_ack = 2'b00;
    endtask

    task automatic rd_beats(input int n, input bit video, input logic [15:0] first, input bit gaps, input bit rnd);
        logic [15:0] prev = '0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    step();
                    bus.sys_rd_data_valid = 1'b0;
                end
            end
            step();
            bus.sys_rd_data_valid = 1'b1;
            bus.sys_dout = rnd ? 16'($urandom) : first + 16'(i);
            if (video && (i % 2 == 1)) vq_q.push_back({bus.sys_dout, prev});
            prev = bus.sys_dout;
        end
        step();
        bus.sys_rd_data_valid = 1'b0;
    endtask

    task automatic wr_beats(input int n, output int taken);
        taken = 0;
        for (int i = 0; i < n; i++) begin
            step();
            bus.sys_wr_data_valid = 1'($urandom_range(0, 1));
            if (bus.sys_wr_data_valid) taken++;
        end
        step();
        bus.sys_wr_data_valid = 1'b0;
    endtask

    initial begin : stim
        int n, base_v, base_c, base_r, n11, first11, taken;
        logic [1:0] code;
        bus.sys_cmd_ack       = 2'b00;
        bus.sys_rd_data_valid = 1'b0;
        bus.sys_wr_data_valid = 1'b0;
        bus.sys_dout          = '0;

        repeat (3) @(posedge clk);
        #3;
        chk("rst_sys_cmd", 64'(bus.sys_cmd), 64'(0));
        chk("rst_sys_addr", 64'(bus.sys_addr), 64'(0));
        chk("rst_vq_wr_en", 64'(vq_wr_en), 64'(0));
        chk("rst_vq_data", 64'(vq_data), 64'(0));
        chk("rst_vid_addr", 64'(vid_addr), 64'(0));
        @(posedge clk);
        #1 rst = 1'b1;

        // Priority
        step();
        vq_almost_empty = 1'b1; cache_wr_req = 1'b1; cache_rd_req = 1'b1;
        cache_waddr = 17'h1ABCD; cpu_line_addr = 17'h0F0F0;
        step();
        chk("prio_video_cmd", 64'(bus.sys_cmd), 64'(2'b10));
        chk("prio_video_addr", 64'(bus.sys_addr), 64'({8'h80, 12'd0, 3'b0}));
        vq_almost_empty = 1'b0;
        step();
        chk("prio_wb_cmd", 64'(bus.sys_cmd), 64'(2'b01));
        chk("prio_wb_addr", 64'(bus.sys_addr), 64'({17'h1ABCD, 6'b0}));
        cache_wr_req = 1'b0;
        step();
        chk("prio_fill_cmd", 64'(bus.sys_cmd), 64'(2'b11));
        cache_rd_req = 1'b0;
        step();

        // Starvation: 64 video slots, one fill, repeat
        vq_almost_empty = 1'b1; cache_rd_req = 1'b1;
        n11 = 0; first11 = 0;
        for (int i = 1; i <= 130; i++) begin
            step();
            if (bus.sys_cmd == 2'b11) begin
                n11++;
                if (first11 == 0) first11 = i;
            end
        end
        chk("starve_fill_count", 64'(n11), 64'(2));
        chk("starve_first_fill", 64'(first11), 64'(65));
        vq_almost_empty = 1'b0; cache_rd_req = 1'b0;
        step();

        // Video index wrap and held ack
        rand_reqs = 1'b1;
        n = 1199 - int'(ref_vid);
        repeat (n) do_ack(2'b10, 1);
        chk("wrap_last", 64'(vid_addr), 64'(1199));
        do_ack(2'b10, 1);
        chk("wrap_zero", 64'(vid_addr), 64'(0));
        do_ack(2'b10, 5);
        chk("ack_held_once", 64'(vid_addr), 64'(1));
        repeat (1250) do_ack(2'b10, $urandom_range(1, 3));

        // Packing of a 16-beat video burst
        do_ack(2'b10, 1);
        base_v = vq_pulses; base_c = cwd_pulses;
        rd_beats(16, 1'b1, 16'h0001, 1'b0, 1'b0);
        repeat (3) step();
        chk("pack_pulses", 64'(vq_pulses - base_v), 64'(8));
        chk("pack_no_cache", 64'(cwd_pulses - base_c), 64'(0));

        // Cache fill and write-back routing
        do_ack(2'b11, 1);
        base_v = vq_pulses; base_c = cwd_pulses;
        rd_beats(128, 1'b0, 16'h0000, 1'b1, 1'b1);
        repeat (2) step();
        chk("fill_pulses", 64'(cwd_pulses - base_c), 64'(128));
        chk("fill_no_vq", 64'(vq_pulses - base_v), 64'(0));
        do_ack(2'b01, 2);
        base_r = crd_pulses;
        wr_beats(40, taken);
        chk("wb_pulses", 64'(crd_pulses - base_r), 64'(taken));

        // Mixed random traffic
        repeat (300) begin
            case ($urandom_range(0, 2))
                0:       code = 2'b10;
                1:       code = 2'b11;
                default: code = 2'b01;
            endcase
            do_ack(code, $urandom_range(1, 3));
            if (code == 2'b01)      wr_beats($urandom_range(1, 24), taken);
            else if (code == 2'b11) rd_beats($urandom_range(1, 24), 1'b0, 16'h0, 1'b1, 1'b1);
            else                    rd_beats($urandom_range(1, 20), 1'b1, 16'h0, 1'b1, 1'b1);
        end

        // Asynchronous reset mid-burst after an odd beat count
        do_ack(2'b10, 1);
        rd_beats(5, 1'b1, 16'hA001, 1'b0, 1'b0);
        step();
        bus.sys_rd_data_valid = 1'b1;
        bus.sys_dout = 16'hA006;
        #6 rst = 1'b0;
        #1;
        chk("arst_sys_cmd", 64'(bus.sys_cmd), 64'(0));
        chk("arst_sys_addr", 64'(bus.sys_addr), 64'(0));
        chk("arst_vq_wr_en", 64'(vq_wr_en), 64'(0));
        chk("arst_vq_data", 64'(vq_data), 64'(0));
        chk("arst_vid_addr", 64'(vid_addr), 64'(0));
        chk("arst_cache_wd", 64'(cache_write_data), 64'(0));
        @(posedge clk);
        #1 rst = 1'b1;
        bus.sys_rd_data_valid = 1'b0;
        for (int i = 7; i <= 9; i++) begin
            step();
            bus.sys_rd_data_valid = 1'b1;
            bus.sys_dout = 16'hA000 + 16'(i);
        end
        vq_q.push_back({16'hA008, 16'hA007});
        step();
        bus.sys_rd_data_valid = 1'b0;
        repeat (3) step();

        // vsync realignment at burst 500
        n = 500 - int'(ref_vid);
        repeat (n) do_ack(2'b10, 1);
        chk("vid_at_500", 64'(vid_addr), 64'(500));
        step();
        vsync = 1'b1;
        repeat (4) step();
        vsync = 1'b0;
        repeat (2) step();
        do_ack(2'b10, 1);
`ifdef SDRAM_VSYNC_RESYNC_EN
        chk("vsync_realign", 64'(vid_addr), 64'(0));
`else
        chk("vsync_ignored", 64'(vid_addr), 64'(501));
`endif

        repeat (4) step();
        chk("vq_queue_drained", 64'(vq_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
